// File: rtl/alu_operand_stage.sv
// ID/EX operand register in front of the ALU: captures one decoded instruction per
// handshake, resolves forwarded operands and the ALU opcode, and holds them while stalled.
module alu_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_alu_class,
    input  logic              in_is_rtype,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7_b5,
    input  logic [1:0]        in_src_a_sel,
    input  logic              in_src_b_sel,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              fwd_exmem_we,
    input  logic [REG_AW-1:0] fwd_exmem_rd,
    input  logic [XLEN-1:0]   fwd_exmem_data,
    input  logic              fwd_memwb_we,
    input  logic [REG_AW-1:0] fwd_memwb_rd,
    input  logic [XLEN-1:0]   fwd_memwb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_alu_op,
    output logic [XLEN-1:0]   out_alu_x,
    output logic [XLEN-1:0]   out_alu_y,
    output logic [XLEN-1:0]   out_store_data,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    // Younger producer (EX/MEM) wins over MEM/WB; x0 is hard-wired to zero.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf_data
    );
        if (rs == '0)
            return '0;
        else if (fwd_exmem_we && fwd_exmem_rd == rs)
            return fwd_exmem_data;
        else if (fwd_memwb_we && fwd_memwb_rd == rs)
            return fwd_memwb_data;
        else
            return rf_data;
    endfunction

    // Returns {illegal, op}.
    function automatic logic [4:0] decode_op(
        input logic [1:0] alu_class,
        input logic       is_rtype,
        input logic [2:0] funct3,
        input logic       funct7_b5
    );
        case (alu_class)
            2'b00: return {1'b0, OP_ADD};
            2'b01: return {1'b0, OP_SUB};
            2'b10: begin
                case (funct3)
                    3'b000:  return {1'b0, (is_rtype && funct7_b5) ? OP_SUB : OP_ADD};
                    3'b111:  return {1'b0, OP_AND};
                    3'b110:  return {1'b0, OP_OR};
                    3'b010:  return {1'b0, OP_SLT};
                    default: return {1'b1, OP_AND};
                endcase
            end
            default: return {1'b1, OP_AND};
        endcase
    endfunction

    logic [XLEN-1:0] rs1_fwd_p0;
    logic [XLEN-1:0] rs2_fwd_p0;
    logic [XLEN-1:0] alu_x_p0;
    logic [XLEN-1:0] alu_y_p0;
    logic [4:0]      dec_p0;
    logic            accept_p0;

    logic              vld_p1;
    logic [3:0]        alu_op_p1;
    logic [XLEN-1:0]   alu_x_p1;
    logic [XLEN-1:0]   alu_y_p1;
    logic [XLEN-1:0]   store_data_p1;
    logic [REG_AW-1:0] rd_addr_p1;
    logic              illegal_p1;

    // Stage p0: operand resolution and decode on the incoming instruction
    assign in_ready   = !vld_p1 || out_ready;
    assign accept_p0  = in_valid && in_ready;
    assign rs1_fwd_p0 = fwd_operand(in_rs1_addr, in_rs1_data);
    assign rs2_fwd_p0 = fwd_operand(in_rs2_addr, in_rs2_data);
    assign dec_p0     = decode_op(in_alu_class, in_is_rtype, in_funct3, in_funct7_b5);

    always_comb begin
        alu_x_p0 = rs1_fwd_p0;
        case (in_src_a_sel)
            2'b01:   alu_x_p0 = in_pc;
            2'b10:   alu_x_p0 = '0;
            default: alu_x_p0 = rs1_fwd_p0;
        endcase
        alu_y_p0 = in_src_b_sel ? in_imm : rs2_fwd_p0;
    end

    // Stage p1: registered operands presented to the ALU
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            alu_op_p1     <= '0;
            alu_x_p1      <= '0;
            alu_y_p1      <= '0;
            store_data_p1 <= '0;
            rd_addr_p1    <= '0;
            illegal_p1    <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1        <= 1'b1;
            alu_op_p1     <= dec_p0[3:0];
            alu_x_p1      <= alu_x_p0;
            alu_y_p1      <= alu_y_p0;
            store_data_p1 <= rs2_fwd_p0;
            rd_addr_p1    <= in_rd_addr;
            illegal_p1    <= dec_p0[4];
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid      = vld_p1;
    assign out_alu_op     = alu_op_p1;
    assign out_alu_x      = alu_x_p1;
    assign out_alu_y      = alu_y_p1;
    assign out_store_data = store_data_p1;
    assign out_rd_addr    = rd_addr_p1;
    assign out_illegal    = illegal_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage: decode, operand select, forwarding,
// stall, flush and reset behaviour against hand-computed expectations.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_alu_class;
    logic        in_is_rtype;
    logic [2:0]  in_funct3;
    logic        in_funct7_b5;
    logic [1:0]  in_src_a_sel;
    logic        in_src_b_sel;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        fwd_exmem_we, fwd_memwb_we;
    logic [4:0]  fwd_exmem_rd, fwd_memwb_rd;
    logic [31:0] fwd_exmem_data, fwd_memwb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [31:0] out_alu_x, out_alu_y, out_store_data;
    logic [4:0]  out_rd_addr;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_class(in_alu_class), .in_is_rtype(in_is_rtype),
        .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
        .in_src_a_sel(in_src_a_sel), .in_src_b_sel(in_src_b_sel),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .fwd_exmem_we(fwd_exmem_we), .fwd_exmem_rd(fwd_exmem_rd), .fwd_exmem_data(fwd_exmem_data),
        .fwd_memwb_we(fwd_memwb_we), .fwd_memwb_rd(fwd_memwb_rd), .fwd_memwb_data(fwd_memwb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_alu_x(out_alu_x), .out_alu_y(out_alu_y),
        .out_store_data(out_store_data), .out_rd_addr(out_rd_addr), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_alu_class = 2'b00; in_is_rtype = 0; in_funct3 = 3'b000;
        in_funct7_b5 = 0; in_src_a_sel = 2'b00; in_src_b_sel = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_pc = 0;
        fwd_exmem_we = 0; fwd_exmem_rd = 0; fwd_exmem_data = 0;
        fwd_memwb_we = 0; fwd_memwb_rd = 0; fwd_memwb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    // Register-register class-10 instruction with no forwarding hits.
    task automatic set_rr(input logic [2:0] f3, input logic b5,
                          input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [4:0] rd);
        in_valid = 1; in_alu_class = 2'b10; in_is_rtype = 1; in_funct3 = f3;
        in_funct7_b5 = b5; in_src_a_sel = 2'b00; in_src_b_sel = 0;
        in_rs1_addr = rs1; in_rs1_data = d1; in_rs2_addr = rs2; in_rs2_data = d2;
        in_rd_addr = rd;
    endtask

    task automatic test_reset();
        clear_inputs();
        in_valid = 1; in_rs1_addr = 5'd1; in_rs1_data = 32'h1234;
        reset = 1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_checks++;
        if ({out_alu_op, out_alu_x, out_alu_y, out_store_data, out_rd_addr, out_illegal} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got x=%h y=%h op=%h exp all zero", out_alu_x, out_alu_y, out_alu_op);
        end
        in_valid = 0;
        reset = 0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_add();
        clear_inputs();
        set_rr(3'b000, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd9);
        tick();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || out_alu_op !== 4'b0010) begin
            n_fail++; $display("FAIL add_op got v=%b op=%b exp v=1 op=0010", out_valid, out_alu_op);
        end
        n_checks++;
        if (out_alu_x !== 32'd5 || out_alu_y !== 32'd7 || out_rd_addr !== 5'd9) begin
            n_fail++; $display("FAIL add_operands got x=%h y=%h rd=%0d exp 5 7 9", out_alu_x, out_alu_y, out_rd_addr);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_sub_addi();
        clear_inputs();
        set_rr(3'b000, 1'b1, 5'd4, 32'd10, 5'd6, 32'd3, 5'd1);
        tick();
        n_checks++;
        if (out_alu_op !== 4'b0110 || out_alu_x !== 32'd10 || out_alu_y !== 32'd3) begin
            n_fail++; $display("FAIL sub got op=%b x=%h y=%h exp 0110 a 3", out_alu_op, out_alu_x, out_alu_y);
        end
        in_is_rtype = 0; in_src_b_sel = 1; in_imm = 32'hFFFF_FFFF;
        tick();
        in_valid = 0;
        n_checks++;
        if (out_alu_op !== 4'b0010 || out_alu_y !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL addi got op=%b y=%h exp 0010 ffffffff", out_alu_op, out_alu_y);
        end
        n_checks++;
        if (out_store_data !== 32'd3) begin
            n_fail++; $display("FAIL addi_store got %h exp 3", out_store_data);
        end
        tick();
    endtask

    task automatic test_forward();
        clear_inputs();
        set_rr(3'b111, 1'b0, 5'd3, 32'h11, 5'd3, 32'h22, 5'd2);
        fwd_exmem_we = 1; fwd_exmem_rd = 5'd3; fwd_exmem_data = 32'hAA;
        fwd_memwb_we = 1; fwd_memwb_rd = 5'd3; fwd_memwb_data = 32'hBB;
        tick();
        n_checks++;
        if (out_alu_x !== 32'hAA || out_store_data !== 32'hAA || out_alu_op !== 4'b0000) begin
            n_fail++; $display("FAIL fwd_exmem got x=%h sd=%h op=%b exp aa aa 0000", out_alu_x, out_store_data, out_alu_op);
        end
        fwd_exmem_we = 0; in_funct3 = 3'b110;
        tick();
        n_checks++;
        if (out_alu_x !== 32'hBB || out_alu_op !== 4'b0001) begin
            n_fail++; $display("FAIL fwd_memwb got x=%h op=%b exp bb 0001", out_alu_x, out_alu_op);
        end
        fwd_exmem_we = 1; fwd_exmem_rd = 5'd0; fwd_exmem_data = 32'hCC;
        fwd_memwb_rd = 5'd0; in_rs1_addr = 5'd0; in_rs1_data = 32'h55; in_funct3 = 3'b010;
        tick();
        n_checks++;
        if (out_alu_x !== 32'h0 || out_alu_op !== 4'b0111) begin
            n_fail++; $display("FAIL fwd_x0 got x=%h op=%b exp 0 0111", out_alu_x, out_alu_op);
        end
        in_src_a_sel = 2'b01; in_pc = 32'h0000_1000;
        tick();
        n_checks++;
        if (out_alu_x !== 32'h0000_1000) begin
            n_fail++; $display("FAIL src_pc got %h exp 1000", out_alu_x);
        end
        in_src_a_sel = 2'b10; in_rs1_addr = 5'd7; in_rs1_data = 32'h77;
        tick();
        in_valid = 0;
        n_checks++;
        if (out_alu_x !== 32'h0) begin
            n_fail++; $display("FAIL src_zero got %h exp 0", out_alu_x);
        end
        tick();
    endtask

    task automatic test_stall();
        clear_inputs();
        out_ready = 0;
        set_rr(3'b000, 1'b0, 5'd1, 32'h100, 5'd2, 32'h200, 5'd5);
        tick();
        set_rr(3'b000, 1'b1, 5'd1, 32'h300, 5'd2, 32'h400, 5'd6);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_alu_x !== 32'h100 ||
                out_alu_y !== 32'h200 || out_rd_addr !== 5'd5 || out_alu_op !== 4'b0010) begin
                n_fail++; $display("FAIL stall_hold cyc%0d got rdy=%b v=%b x=%h y=%h exp 0 1 100 200",
                                   i, in_ready, out_valid, out_alu_x, out_alu_y);
            end
            tick();
        end
        out_ready = 1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || out_alu_x !== 32'h300 || out_alu_op !== 4'b0110 || out_rd_addr !== 5'd6) begin
            n_fail++; $display("FAIL stall_next got v=%b x=%h op=%b exp 1 300 0110", out_valid, out_alu_x, out_alu_op);
        end
        tick();
    endtask

    task automatic test_flush();
        clear_inputs();
        out_ready = 0;
        set_rr(3'b000, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
        tick();
        set_rr(3'b111, 1'b0, 5'd1, 32'h9, 5'd2, 32'h8, 5'd4);
        flush = 1;
        tick();
        flush = 0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        in_valid = 0; out_ready = 1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_emit got %b exp 0", out_valid); end
        // flush wins over an accept offered in the same cycle
        set_rr(3'b000, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
        flush = 1;
        tick();
        flush = 0; in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_beats_accept got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        clear_inputs();
        set_rr(3'b001, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_alu_op !== 4'b0000 || out_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_f3 got v=%b op=%b ill=%b exp 1 0000 1", out_valid, out_alu_op, out_illegal);
        end
        in_alu_class = 2'b11; in_funct3 = 3'b000;
        tick();
        n_checks++;
        if (out_illegal !== 1'b1 || out_alu_op !== 4'b0000) begin
            n_fail++; $display("FAIL illegal_class got op=%b ill=%b exp 0000 1", out_alu_op, out_illegal);
        end
        in_alu_class = 2'b01;
        tick();
        n_checks++;
        if (out_illegal !== 1'b0 || out_alu_op !== 4'b0110) begin
            n_fail++; $display("FAIL class_sub got op=%b ill=%b exp 0110 0", out_alu_op, out_illegal);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        out_ready = 0;
        set_rr(3'b000, 1'b0, 5'd1, 32'h44, 5'd2, 32'h55, 5'd7);
        tick();
        in_valid = 0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_alu_x !== 32'h44) begin
            n_fail++; $display("FAIL rstall_pre got v=%b x=%h exp 1 44", out_valid, out_alu_x);
        end
        reset = 1;
        tick();
        reset = 0;
        n_checks++;
        if (out_valid !== 1'b0 || out_alu_x !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstall got v=%b x=%h rdy=%b exp 0 0 1", out_valid, out_alu_x, in_ready);
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_add();
        test_sub_addi();
        test_forward();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
